control_fsm: RTL and testbench
==============================

// Module: control_fsm
// PURPOSE
//  Multi-cycle control unit driving the single-cycle-per-stage datapath (IF/DEC/ALU/MEM).
//  Decodes instr[31:26] (and instr[3:0] for R-type), sequences FETCH..WRITEBACK, and
//  drives PC enable/select, RF write source/enable, RF B-port select, ALU B source/func, MEM write.
//  Sits directly upstream of the datapath; consumes its instr and zero outputs.
// PARAMETERS
//  MEM_WAIT  1  extra cycles each memory access state is held (0..7); MEM state lasts MEM_WAIT+1 cycles
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  reset     in   1   synchronous, active-high
//  instr     in   32  current instruction from datapath
//  zero      in   1   ALU zero flag from datapath (combinational, same cycle)
//  en        out  1   PC write enable; one-cycle pulse in last cycle of every instruction
//  PC_sel    out  1   0: PC+4, 1: PC+4+immed (branch target)
//  RFsel_wr  out  1   RF write data: 0 ALU_out, 1 MEM_out
//  RFsel_B   out  1   RF B read address: 0 instr[15:11], 1 instr[20:16]
//  RFwr_en   out  1   RF write enable
//  ALUsel_B  out  1   ALU B operand: 0 RF_B, 1 immed
//  MEMwr_en  out  1   data memory write enable
//  func      out  4   ALU op: 0000 add,0001 sub,0010 and,0011 or,0100 not,0101 nand,0110 nor,
//                     1000 sra,1001 srl,1010 sll,1100 rol,1101 ror
//  illegal   out  1   one-cycle pulse in DECODE when opcode is unrecognised
// BEHAVIOUR
//  Opcodes: 100000 R-type (func=instr[3:0]); 111000 li,111001 lui,110000 addi (add,imm);
//   110010 nandi (nand,imm); 110011 ori (or,imm); 111111 b; 010000 beq; 010001 bne;
//   000011 lb, 001111 lw (load); 000111 sb, 011111 sw (store). Byte masking is done in datapath.
//  States: FETCH, DECODE, EXEC, WB_ALU, MADDR, MRD, MWR, WB_MEM, BRANCH.
//  FETCH->DECODE always. DECODE-> EXEC (R/ALU-imm), MADDR (load/store), BRANCH (b/beq/bne),
//   FETCH with en=1,PC_sel=0 and illegal=1 (unrecognised: executes as nop).
//  EXEC->WB_ALU; WB_ALU->FETCH. MADDR->MRD (load) or MWR (store).
//  MRD/MWR: 3-bit wait counter loaded with MEM_WAIT on entry; leave when counter==0.
//  MRD->WB_MEM; WB_MEM->FETCH; MWR->FETCH; BRANCH->FETCH.
//  Outputs (Moore on state, except PC_sel in BRANCH):
//   EXEC/WB_ALU: func, ALUsel_B per instr held stable both cycles; WB_ALU: RFwr_en=1,RFsel_wr=0,en=1.
//   MADDR/MRD/MWR/WB_MEM: func=0000, ALUsel_B=1 held stable. MWR: RFsel_B=1, MEMwr_en=1 every
//   MWR cycle, en=1 in final MWR cycle. WB_MEM: RFwr_en=1, RFsel_wr=1, en=1.
//   BRANCH: func=0001, ALUsel_B=0, RFsel_B=1, en=1; PC_sel = 1 (b), zero (beq), ~zero (bne).
//  All outputs not listed for a state are 0. Exactly one en pulse per instruction.
//  Latency (cycles, FETCH..last): ALU 4; load 5+MEM_WAIT; store 4+MEM_WAIT; branch 3; illegal 2.
//  Reset: while reset=1 all outputs forced 0 (combinationally gated, so no write escapes in the
//   reset cycle); next edge state=FETCH, counter=0. Reset mid-MWR aborts the store after that cycle.
//  RFwr_en and MEMwr_en are never asserted in the same cycle; PC_sel=0 whenever en=0.
// TESTING
//  add r3,r1,r2 (100000, func 110000 -> 0000) after reset -> DECODE,EXEC,WB_ALU; RFwr_en=1,en=1 at cycle 4 only.
//  lw with MEM_WAIT=2 -> RFwr_en=1,RFsel_wr=1,en=1 at cycle 7; ALUsel_B=1,func=0000 cycles 3-7.
//  sw with MEM_WAIT=0 -> MEMwr_en=1,RFsel_B=1 in cycle 4 only, en=1 same cycle, RFwr_en=0 throughout.
//  beq with zero=1 -> en=1,PC_sel=1 cycle 3; repeat with zero=0 -> en=1,PC_sel=0; bne inverse.
//  opcode 101010 -> illegal=1 and en=1,PC_sel=0 at cycle 2; next cycle FETCH.
//  reset asserted during MWR (MEM_WAIT=3) -> MEMwr_en=0 that cycle, FETCH next, all outputs 0.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the IF/DEC/ALU/MEM datapath.
// Sequences each instruction from FETCH to its last cycle.
module control_fsm #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        en,
    output logic        PC_sel,
    output logic        RFsel_wr,
    output logic        RFsel_B,
    output logic        RFwr_en,
    output logic        ALUsel_B,
    output logic        MEMwr_en,
    output logic [3:0]  func,
    output logic        illegal
);

    localparam logic [5:0] OP_R     = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_NANDI = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b0001;
    localparam logic [3:0] F_OR   = 4'b0011;
    localparam logic [3:0] F_NAND = 4'b0101;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB_ALU,
        S_MADDR,
        S_MRD,
        S_MWR,
        S_WB_MEM,
        S_BRANCH
    } state_t;

    typedef enum logic [1:0] {
        BR_ALWAYS,
        BR_EQ,
        BR_NE
    } br_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] func_q;
    logic       alub_q;
    logic       store_q;
    br_t        br_q;

    logic [5:0] op;
    logic       dec_alu;
    logic       dec_mem;
    logic       dec_store;
    logic       dec_br;
    logic       dec_bad;
    logic [3:0] dec_func;
    logic       dec_alub;
    br_t        dec_brt;

    logic       o_en;
    logic       o_pc_sel;
    logic       o_rfsel_wr;
    logic       o_rfsel_b;
    logic       o_rfwr_en;
    logic       o_alusel_b;
    logic       o_memwr_en;
    logic [3:0] o_func;
    logic       o_illegal;

    logic       unused_bits;

    assign op          = instr[31:26];
    assign unused_bits = ^instr[25:4];

    // Classify the opcode; R-type takes its ALU op from the low nibble.
    always_comb begin
        dec_alu   = 1'b0;
        dec_mem   = 1'b0;
        dec_store = 1'b0;
        dec_br    = 1'b0;
        dec_bad   = 1'b0;
        dec_func  = F_ADD;
        dec_alub  = 1'b1;
        dec_brt   = BR_ALWAYS;
        unique case (1'b1)
            (op == OP_R): begin
                dec_alu  = 1'b1;
                dec_func = instr[3:0];
                dec_alub = 1'b0;
            end
            (op == OP_LI),
            (op == OP_LUI),
            (op == OP_ADDI): begin
                dec_alu  = 1'b1;
            end
            (op == OP_NANDI): begin
                dec_alu  = 1'b1;
                dec_func = F_NAND;
            end
            (op == OP_ORI): begin
                dec_alu  = 1'b1;
                dec_func = F_OR;
            end
            (op == OP_LB),
            (op == OP_LW): begin
                dec_mem = 1'b1;
            end
            (op == OP_SB),
            (op == OP_SW): begin
                dec_mem   = 1'b1;
                dec_store = 1'b1;
            end
            (op == OP_B): begin
                dec_br  = 1'b1;
            end
            (op == OP_BEQ): begin
                dec_br  = 1'b1;
                dec_brt = BR_EQ;
            end
            (op == OP_BNE): begin
                dec_br  = 1'b1;
                dec_brt = BR_NE;
            end
            default: begin
                dec_bad = 1'b1;
            end
        endcase
    end

    // State, wait counter and decode results captured in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 3'd0;
            func_q  <= F_ADD;
            alub_q  <= 1'b0;
            store_q <= 1'b0;
            br_q    <= BR_ALWAYS;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                func_q  <= dec_func;
                alub_q  <= dec_alub;
                store_q <= dec_store;
                br_q    <= dec_brt;
            end
        end
    end

    // Next state and raw Moore outputs (PC_sel also follows zero).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o_en       = 1'b0;
        o_pc_sel   = 1'b0;
        o_rfsel_wr = 1'b0;
        o_rfsel_b  = 1'b0;
        o_rfwr_en  = 1'b0;
        o_alusel_b = 1'b0;
        o_memwr_en = 1'b0;
        o_func     = F_ADD;
        o_illegal  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    dec_alu: state_d = S_EXEC;
                    dec_mem: state_d = S_MADDR;
                    dec_br:  state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        o_en      = 1'b1;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                o_func     = func_q;
                o_alusel_b = alub_q;
                state_d    = S_WB_ALU;
            end
            S_WB_ALU: begin
                o_func     = func_q;
                o_alusel_b = alub_q;
                o_rfwr_en  = 1'b1;
                o_en       = 1'b1;
                state_d    = S_FETCH;
            end
            S_MADDR: begin
                o_alusel_b = 1'b1;
                cnt_d      = WAIT_INIT;
                state_d    = store_q ? S_MWR : S_MRD;
            end
            S_MRD: begin
                o_alusel_b = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = S_WB_MEM;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_MWR: begin
                o_alusel_b = 1'b1;
                o_rfsel_b  = 1'b1;
                o_memwr_en = 1'b1;
                if (cnt_q == 3'd0) begin
                    o_en    = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WB_MEM: begin
                o_alusel_b = 1'b1;
                o_rfwr_en  = 1'b1;
                o_rfsel_wr = 1'b1;
                o_en       = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                o_func    = F_SUB;
                o_rfsel_b = 1'b1;
                o_en      = 1'b1;
                unique case (br_q)
                    BR_EQ:   o_pc_sel = zero;
                    BR_NE:   o_pc_sel = ~zero;
                    default: o_pc_sel = 1'b1;
                endcase
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Gate every output with reset so no write escapes the reset cycle.
    always_comb begin
        en       = o_en       & ~reset;
        PC_sel   = o_pc_sel   & ~reset;
        RFsel_wr = o_rfsel_wr & ~reset;
        RFsel_B  = o_rfsel_b  & ~reset;
        RFwr_en  = o_rfwr_en  & ~reset;
        ALUsel_B = o_alusel_b & ~reset;
        MEMwr_en = o_memwr_en & ~reset;
        func     = reset ? 4'b0000 : o_func;
        illegal  = o_illegal  & ~reset;
    end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm.
// Expected outputs come from a per-cycle instruction timeline model.
module tb_control_fsm;

    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        en, PC_sel, RFsel_wr, RFsel_B, RFwr_en;
    logic        ALUsel_B, MEMwr_en, illegal;
    logic [3:0]  func;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;

    control_fsm #(.MEM_WAIT(MW)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .zero     (zero),
        .en       (en),
        .PC_sel   (PC_sel),
        .RFsel_wr (RFsel_wr),
        .RFsel_B  (RFsel_B),
        .RFwr_en  (RFwr_en),
        .ALUsel_B (ALUsel_B),
        .MEMwr_en (MEMwr_en),
        .func     (func),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    assign obs = {en, PC_sel, RFsel_wr, RFsel_B, RFwr_en,
                  ALUsel_B, MEMwr_en, func, illegal};

    // 0 illegal, 1 alu, 2 load, 3 store, 4 branch
    function automatic int kind(input logic [5:0] op);
        case (op)
            6'b100000, 6'b111000, 6'b111001,
            6'b110000, 6'b110010, 6'b110011: return 1;
            6'b000011, 6'b001111:            return 2;
            6'b000111, 6'b011111:            return 3;
            6'b111111, 6'b010000, 6'b010001: return 4;
            default:                         return 0;
        endcase
    endfunction

    function automatic int lat(input logic [31:0] ins);
        case (kind(ins[31:26]))
            1:       return 4;
            2:       return 5 + MW;
            3:       return 4 + MW;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // Expected output vector in cycle k (1 = FETCH) of instruction ins.
    function automatic logic [11:0] expv(input logic [31:0] ins,
                                         input logic z, input int k);
        logic e, ps, rw, rb, rwe, ab, mw, il;
        logic [3:0] f;
        int n;
        logic [5:0] op;
        e = 0; ps = 0; rw = 0; rb = 0; rwe = 0;
        ab = 0; mw = 0; il = 0; f = 4'd0;
        op = ins[31:26];
        n = lat(ins);
        case (kind(op))
            0: if (k == 2) begin e = 1; il = 1; end
            1: if (k >= 3) begin
                if (op == 6'b100000) f = ins[3:0];
                else if (op == 6'b110010) f = 4'b0101;
                else if (op == 6'b110011) f = 4'b0011;
                ab = (op != 6'b100000);
                if (k == 4) begin rwe = 1; e = 1; end
            end
            2: if (k >= 3) begin
                ab = 1;
                if (k == n) begin rwe = 1; rw = 1; e = 1; end
            end
            3: if (k >= 3) begin
                ab = 1;
                if (k >= 4) begin rb = 1; mw = 1; end
                if (k == n) e = 1;
            end
            default: if (k == 3) begin
                f = 4'b0001; rb = 1; e = 1;
                if (op == 6'b111111) ps = 1;
                else if (op == 6'b010000) ps = z;
                else ps = ~z;
            end
        endcase
        return {e, ps, rw, rb, rwe, ab, mw, f, il};
    endfunction

    // Drive one cycle, sample at the falling edge, advance past the rise.
    task automatic step(input logic [31:0] ins, input int k,
                        output logic [11:0] got, output logic [11:0] want);
        instr = ins;
        zero  = 1'($urandom);
        @(negedge clk);
        got  = obs;
        want = expv(ins, zero, k);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        instr = {6'b100000, 26'd0};
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 12'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_alu;
        logic [11:0] g, w;
        logic [31:0] ins [3];
        ins[0] = 32'h8022_1830;
        ins[1] = {6'b110010, 26'h123_4567};
        ins[2] = {6'b100000, 22'h2a_aaaa, 4'b1101};
        foreach (ins[i]) begin
            for (int k = 1; k <= lat(ins[i]); k++) begin
                step(ins[i], k, g, w);
                checks++;
                if (g !== w) begin
                    errors++;
                    $display("FAIL alu i=%0d k=%0d got=%b want=%b",
                             i, k, g, w);
                end
            end
        end
    endtask

    task automatic test_load;
        logic [11:0] g, w;
        logic [31:0] ins;
        ins = {6'b001111, 26'h0abcdef};
        for (int k = 1; k <= lat(ins); k++) begin
            step(ins, k, g, w);
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL load k=%0d got=%b want=%b", k, g, w);
            end
        end
    endtask

    task automatic test_store;
        logic [11:0] g, w;
        logic [31:0] ins;
        ins = {6'b011111, 26'h1555555};
        for (int k = 1; k <= lat(ins); k++) begin
            step(ins, k, g, w);
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL store k=%0d got=%b want=%b", k, g, w);
            end
        end
    endtask

    task automatic test_branch;
        logic [11:0] g, w;
        logic [5:0] ops [3];
        ops[0] = 6'b111111;
        ops[1] = 6'b010000;
        ops[2] = 6'b010001;
        for (int r = 0; r < 4; r++) begin
            foreach (ops[i]) begin
                for (int k = 1; k <= 3; k++) begin
                    step({ops[i], 26'h0000040}, k, g, w);
                    checks++;
                    if (g !== w) begin
                        errors++;
                        $display("FAIL branch op=%b k=%0d got=%b want=%b",
                                 ops[i], k, g, w);
                    end
                end
            end
        end
    endtask

    task automatic test_illegal;
        logic [11:0] g, w;
        logic [31:0] ins;
        ins = {6'b101010, 26'h3ffffff};
        for (int k = 1; k <= 2; k++) begin
            step(ins, k, g, w);
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL illegal k=%0d got=%b want=%b", k, g, w);
            end
        end
        step(32'h8022_1830, 1, g, w);
        checks++;
        if (g !== w) begin
            errors++;
            $display("FAIL illegal_next_fetch got=%b want=%b", g, w);
        end
        for (int k = 2; k <= 4; k++) begin
            step(32'h8022_1830, k, g, w);
        end
    endtask

    task automatic test_reset_mid_store;
        logic [11:0] g, w;
        logic [31:0] st;
        st = {6'b000111, 26'h0000004};
        for (int k = 1; k <= 4; k++) begin
            step(st, k, g, w);
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL mid_store k=%0d got=%b want=%b", k, g, w);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("FAIL mid_store_reset got=%b want=%b", obs, 12'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(32'h8022_1830, k, g, w);
            checks++;
            if (g !== w) begin
                errors++;
                $display("FAIL after_reset k=%0d got=%b want=%b", k, g, w);
            end
        end
    endtask

    task automatic test_random;
        logic [11:0] g, w;
        logic [31:0] r, ins;
        logic [5:0] op;
        logic [5:0] tbl [13];
        tbl = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                6'b110011, 6'b111111, 6'b010000, 6'b010001, 6'b000011,
                6'b001111, 6'b000111, 6'b011111};
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = tbl[$urandom_range(0, 12)];
            ins = {op, r[25:0]};
            for (int k = 1; k <= lat(ins); k++) begin
                step(ins, k, g, w);
                checks++;
                if (g !== w) begin
                    errors++;
                    $display("FAIL random n=%0d instr=%h k=%0d got=%b want=%b",
                             n, ins, k, g, w);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_branch;
        test_illegal;
        test_reset_mid_store;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
